time_keeper: RTL and testbench

Binary timekeeping core for the digital clock. Divides the board clock down to a 1 Hz tick and maintains seconds, minutes and hours (24-hour) as binary counts. Supports hour and minute setting through a three-state mode FSM driven by debounced button pulses. Its mins/hours outputs feed the binary-to-BCD stage directly, and the blink/edit flags go to the display driver.

---
 rtl/time_keeper.sv | 79 +++++++
 tb/tb_time_keeper.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/time_keeper.sv
// time_keeper: 1 Hz prescaler plus 24-hour binary clock with hour/minute edit modes.
module time_keeper #(
    parameter int CLKS_PER_SEC = 100000000,
    parameter int PRESC_W      = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       up_btn,
    input  logic       down_btn,
    output logic [5:0] secs,
    output logic [5:0] mins,
    output logic [4:0] hours,
    output logic       sec_pulse,
    output logic       edit_hr,
    output logic       edit_min,
    output logic       blink
);
    typedef enum logic [1:0] {RUN, SET_HR, SET_MIN} state_t;
    localparam logic [PRESC_W-1:0] LAST = PRESC_W'(CLKS_PER_SEC - 1);
    localparam logic [PRESC_W-1:0] HALF = PRESC_W'(CLKS_PER_SEC / 2);
    state_t state, state_nx;
    logic [PRESC_W-1:0] presc, presc_nx;
    logic [5:0] secs_nx, mins_nx;
    logic [4:0] hours_nx;
    logic tick, up, dn;
    assign tick  = presc == LAST;
    assign blink = presc < HALF;
    // mode_btn takes priority, so edit pulses only count when it is idle
    assign up = up_btn & ~down_btn & ~mode_btn;
    assign dn = down_btn & ~up_btn & ~mode_btn;
    always_comb begin
        state_nx = !mode_btn ? state : state == RUN ? SET_HR : state == SET_HR ? SET_MIN : RUN;
    end
    always_comb begin
        secs_nx  = secs;
        mins_nx  = mins;
        hours_nx = hours;
        presc_nx = tick ? '0 : presc + PRESC_W'(1);
        if (state == RUN && tick) begin
            secs_nx = secs == 6'd59 ? 6'd0 : secs + 6'd1;
            if (secs == 6'd59) begin
                mins_nx = mins == 6'd59 ? 6'd0 : mins + 6'd1;
                if (mins == 6'd59)
                    hours_nx = hours == 5'd23 ? 5'd0 : hours + 5'd1;
            end
        end
        if (state == SET_HR && up) hours_nx = hours == 5'd23 ? 5'd0 : hours + 5'd1;
        if (state == SET_HR && dn) hours_nx = hours == 5'd0 ? 5'd23 : hours - 5'd1;
        if (state == SET_MIN && up) mins_nx = mins == 6'd59 ? 6'd0 : mins + 6'd1;
        if (state == SET_MIN && dn) mins_nx = mins == 6'd0 ? 6'd59 : mins - 6'd1;
        // returning to RUN restarts the second so the first tick is a full second away
        if (state == SET_MIN && mode_btn) begin
            secs_nx  = 6'd0;
            presc_nx = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            presc     <= '0;
            secs      <= 6'd0;
            mins      <= 6'd0;
            hours     <= 5'd0;
            sec_pulse <= 1'b0;
            edit_hr   <= 1'b0;
            edit_min  <= 1'b0;
        end else begin
            state     <= state_nx;
            presc     <= presc_nx;
            secs      <= secs_nx;
            mins      <= mins_nx;
            hours     <= hours_nx;
            sec_pulse <= tick && state == RUN;
            edit_hr   <= state_nx == SET_HR;
            edit_min  <= state_nx == SET_MIN;
        end
    end
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: random and directed stimulus checked every cycle against a time-of-day model.
module tb_time_keeper;
    localparam int N = 4;
    logic clk = 1'b0, reset = 1'b1, mode_btn = 1'b0, up_btn = 1'b0, down_btn = 1'b0;
    logic [5:0] secs, mins;
    logic [4:0] hours;
    logic sec_pulse, edit_hr, edit_min, blink;
    int vectors = 0, miscompares = 0;
    int m_total = 0, m_phase = 0, m_mode = 0;
    bit m_pulse = 0, checking = 0;

    time_keeper #(.CLKS_PER_SEC(N), .PRESC_W(3)) dut (
        .clk(clk), .reset(reset), .mode_btn(mode_btn), .up_btn(up_btn), .down_btn(down_btn),
        .secs(secs), .mins(mins), .hours(hours), .sec_pulse(sec_pulse),
        .edit_hr(edit_hr), .edit_min(edit_min), .blink(blink)
    );

    always #5 clk = ~clk;

    // model: time of day as total seconds, mode 0=run 1=hours 2=minutes, phase within the second
    function automatic void model_update(input bit r, input bit m, input bit u, input bit d);
        int h, mi, s, ph;
        bit tick;
        h = m_total / 3600; mi = (m_total / 60) % 60; s = m_total % 60;
        tick = (m_phase == N - 1);
        if (r) begin
            m_total = 0; m_phase = 0; m_mode = 0; m_pulse = 0;
            return;
        end
        m_pulse = tick && m_mode == 0;
        ph = tick ? 0 : m_phase + 1;
        if (m_mode == 0 && tick) m_total = (m_total + 1) % 86400;
        else if (!m && u != d) begin
            if (m_mode == 1) h = (h + (u ? 1 : 23)) % 24;
            if (m_mode == 2) mi = (mi + (u ? 1 : 59)) % 60;
            m_total = h * 3600 + mi * 60 + s;
        end
        if (m) begin
            if (m_mode == 2) begin
                m_total = m_total - m_total % 60;
                ph = 0;
            end
            m_mode = (m_mode + 1) % 3;
        end
        m_phase = ph;
    endfunction

    task automatic step(input bit r, input bit m, input bit u, input bit d);
        reset = r; mode_btn = m; up_btn = u; down_btn = d;
        @(posedge clk);
        model_update(r, m, u, d);
        #1;
        reset = 0; mode_btn = 0; up_btn = 0; down_btn = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        int es, em, eh;
        bit eb;
        if (checking) begin
            es = m_total % 60; em = (m_total / 60) % 60; eh = m_total / 3600;
            eb = m_phase < N / 2;
            vectors++;
            if (secs !== 6'(es) || mins !== 6'(em) || hours !== 5'(eh) || sec_pulse !== m_pulse ||
                edit_hr !== (m_mode == 1) || edit_min !== (m_mode == 2) || blink !== eb) begin
                miscompares++;
                $display("FAIL outputs @%0t: got %0d:%0d:%0d p=%b eh=%b em=%b bl=%b, expected %0d:%0d:%0d p=%b eh=%b em=%b bl=%b",
                         $time, hours, mins, secs, sec_pulse, edit_hr, edit_min, blink,
                         eh, em, es, m_pulse, m_mode == 1, m_mode == 2, eb);
            end
        end
    end

    initial begin
        int pulses, bad, rises, k_found;
        logic prev_blink;
        logic [5:0] fs, fm;
        logic [4:0] fh;
        step(1, 0, 0, 0);
        checking = 1;
        chk("rst_secs", int'(secs), 0);
        chk("rst_blink", int'(blink), 1);
        chk("rst_edit_hr", int'(edit_hr), 0);
        pulses = 0; bad = 0;
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 0, 0);
            if (sec_pulse) begin
                pulses++;
                if (i % 4 != 0) bad++;
            end
        end
        chk("run16_secs", int'(secs), 4);
        chk("run16_pulses", pulses, 4);
        chk("run16_spacing", bad, 0);
        // preload 23:59 via the edit states
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        chk("preload_hours", int'(hours), 23);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        chk("preload_mins", int'(mins), 59);
        step(0, 1, 0, 0);
        chk("exit_secs", int'(secs), 0);
        idle(59 * N);
        chk("pre_roll", int'(hours) * 3600 + int'(mins) * 60 + int'(secs), 23 * 3600 + 59 * 60 + 59);
        idle(N);
        chk("rollover", int'(hours) * 3600 + int'(mins) * 60 + int'(secs), 0);
        // hour and minute wrap in edit
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        chk("hr_down_wrap", int'(hours), 23);
        step(0, 0, 1, 0);
        chk("hr_up_wrap", int'(hours), 0);
        step(0, 0, 0, 1);
        chk("hr_down_again", int'(hours), 23);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        chk("min_down_wrap", int'(mins), 59);
        chk("min_edit_hours", int'(hours), 23);
        // frozen while editing minutes
        fs = secs; fm = mins; fh = hours;
        pulses = 0; rises = 0; prev_blink = blink;
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 0, 0);
            if (sec_pulse) pulses++;
            if (blink && !prev_blink) rises++;
            prev_blink = blink;
        end
        chk("hold_frozen", int'({fh, fm, fs} == {hours, mins, secs}), 1);
        chk("hold_pulses", pulses, 0);
        chk("hold_blink_rises", rises, 10);
        step(0, 1, 0, 0);
        chk("resume_secs", int'(secs), 0);
        chk("resume_edit_min", int'(edit_min), 0);
        k_found = -1;
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 0, 0);
            if (sec_pulse) begin
                k_found = k;
                break;
            end
        end
        chk("first_pulse_delay", k_found, N);
        // simultaneous buttons in SET_HR
        step(0, 1, 0, 0);
        step(0, 0, 1, 1);
        chk("updown_hours", int'(hours), 23);
        step(0, 1, 1, 0);
        chk("mode_up_state", int'(edit_min), 1);
        chk("mode_up_hours", int'(hours), 23);
        // reset in the middle of an hour edit
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0);
        chk("set_hours7", int'(hours), 7);
        step(1, 0, 0, 0);
        chk("edit_rst_time", int'(hours) + int'(mins) + int'(secs), 0);
        chk("edit_rst_edit_hr", int'(edit_hr), 0);
        chk("edit_rst_pulse", int'(sec_pulse), 0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
